// File: rtl/i2c_cmd_scheduler.sv
// Single-command scheduler in front of module_i2c: round-robin arbitration of two
// requesters, TX FIFO push / RX FIFO pop, core mode control, timeout and error abort.
module i2c_cmd_scheduler #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 14,
  parameter int unsigned TMO_W  = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_rw,
  input  logic [2*DWIDTH-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DWIDTH-1:0]     rsp_rdata,
  output logic [1:0]            rsp_err,
  input  logic [TMO_W-1:0]      tmo_cycles,
  output logic                  fifo_tx_wr_en,
  output logic [DWIDTH-1:0]     fifo_tx_data_in,
  input  logic                  fifo_tx_f_full,
  output logic                  fifo_rx_rd_en,
  input  logic [DWIDTH-1:0]     fifo_rx_data_out,
  input  logic                  RX_EMPTY,
  input  logic                  i2c_idle,
  input  logic                  ERROR,
  output logic [AWIDTH-1:0]     DATA_CONFIG_REG,
  output logic [AWIDTH-1:0]     TIMEOUT_TX,
  output logic                  busy
);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_TMO  = 2'b01;
  localparam logic [1:0] ERR_CORE = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_GO_TX, S_WAIT_TX, S_GO_RX, S_WAIT_RX, S_POP, S_CAPTURE, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic                started_q, started_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic [1:0]          cfg_q, cfg_d;
  logic                wr_en_q, wr_en_d;
  logic [DWIDTH-1:0]   tx_data_q, tx_data_d;
  logic                rd_en_q, rd_en_d;
  logic [AWIDTH-1:0]   tmo_reg_q;
  logic                busy_q, busy_d;

  logic                grant_c;
  logic                counting_c;
  logic                tmo_hit_c;
  logic                err_abort_c;
  logic                tmo_abort_c;

  assign grant_c     = req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign counting_c  = (state_q == S_PUSH) || (state_q == S_WAIT_TX) || (state_q == S_WAIT_RX);
  assign tmo_hit_c   = (tmo_cycles != '0) && (cnt_q == tmo_cycles - TMO_W'(1));
  assign err_abort_c = ERROR && (state_q != S_IDLE) && (state_q != S_RESP);

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    started_d   = started_q;
    wdata_d     = wdata_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cfg_d       = cfg_q;
    wr_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    rd_en_d     = 1'b0;
    req_ready   = 2'b00;
    tmo_abort_c = 1'b0;

    if (counting_c) cnt_d = cnt_q + TMO_W'(1);

    case (state_q)
      S_IDLE: begin
        req_ready = (grant_c ? 2'b10 : 2'b01) & req_valid;
        if (req_valid[grant_c]) begin
          wdata_d   = grant_c ? req_wdata[2*DWIDTH-1:DWIDTH] : req_wdata[DWIDTH-1:0];
          id_d      = grant_c;
          ptr_d     = ~grant_c;
          cnt_d     = '0;
          started_d = 1'b0;
          state_d   = req_rw[grant_c] ? S_GO_RX : S_PUSH;
        end
      end
      S_PUSH: begin
        if (!fifo_tx_f_full) begin
          wr_en_d   = 1'b1;
          tx_data_d = wdata_q;
          state_d   = S_GO_TX;
        end else if (tmo_hit_c) begin
          tmo_abort_c = 1'b1;
        end
      end
      S_GO_TX: begin
        cfg_d   = 2'b01;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        // Completion needs the core to have left IDLE at least once
        if (started_q && i2c_idle) begin
          cfg_d       = 2'b00;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_OK;
          state_d     = S_RESP;
        end else if (tmo_hit_c) begin
          tmo_abort_c = 1'b1;
        end else if (!i2c_idle) begin
          started_d = 1'b1;
        end
      end
      S_GO_RX: begin
        cfg_d   = 2'b10;
        state_d = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        if (!RX_EMPTY) begin
          rd_en_d = 1'b1;
          state_d = S_POP;
        end else if (tmo_hit_c) begin
          tmo_abort_c = 1'b1;
        end
      end
      S_POP: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        cfg_d       = 2'b00;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_rdata_d = fifo_rx_data_out;
        rsp_err_d   = ERR_OK;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort path; a core error overrides timeout and completion
    if (tmo_abort_c || err_abort_c) begin
      cfg_d       = 2'b00;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_id_d    = id_q;
      rsp_rdata_d = '0;
      rsp_err_d   = err_abort_c ? ERR_CORE : ERR_TMO;
      state_d     = S_RESP;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      started_q   <= 1'b0;
      wdata_q     <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
      cfg_q       <= 2'b00;
      wr_en_q     <= 1'b0;
      tx_data_q   <= '0;
      rd_en_q     <= 1'b0;
      tmo_reg_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      started_q   <= started_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cfg_q       <= cfg_d;
      wr_en_q     <= wr_en_d;
      tx_data_q   <= tx_data_d;
      rd_en_q     <= rd_en_d;
      tmo_reg_q   <= AWIDTH'(tmo_cycles);
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign fifo_tx_wr_en   = wr_en_q;
  assign fifo_tx_data_in = tx_data_q;
  assign fifo_rx_rd_en   = rd_en_q;
  assign DATA_CONFIG_REG = {{(AWIDTH-2){1'b0}}, cfg_q};
  assign TIMEOUT_TX      = tmo_reg_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// Self-checking bench for i2c_cmd_scheduler: directed scenarios plus randomized
// commands checked against a transaction-level model of arbitration and responses.
module tb_i2c_cmd_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 14;
  localparam int unsigned TW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_rw;
  logic [2*DW-1:0] req_wdata;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_err;
  logic [TW-1:0]   tmo_cycles;
  logic            fifo_tx_wr_en, fifo_tx_f_full, fifo_rx_rd_en;
  logic [DW-1:0]   fifo_tx_data_in, fifo_rx_data_out;
  logic            RX_EMPTY, i2c_idle, ERROR, busy;
  logic [AW-1:0]   DATA_CONFIG_REG, TIMEOUT_TX;

  i2c_cmd_scheduler #(.DWIDTH(DW), .AWIDTH(AW), .TMO_W(TW)) dut (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .tmo_cycles(tmo_cycles),
    .fifo_tx_wr_en(fifo_tx_wr_en), .fifo_tx_data_in(fifo_tx_data_in), .fifo_tx_f_full(fifo_tx_f_full),
    .fifo_rx_rd_en(fifo_rx_rd_en), .fifo_rx_data_out(fifo_rx_data_out), .RX_EMPTY(RX_EMPTY),
    .i2c_idle(i2c_idle), .ERROR(ERROR),
    .DATA_CONFIG_REG(DATA_CONFIG_REG), .TIMEOUT_TX(TIMEOUT_TX), .busy(busy)
  );

  always #5 clk = ~clk;

  int          total, passed, failed;
  int          cyc, wr_cnt, rd_cnt;
  logic [31:0] last_wr;
  bit          in_cmd;
  bit          ptr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; samples strobes and invariants on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (fifo_tx_wr_en) begin
      wr_cnt++;
      last_wr = fifo_tx_data_in;
    end
    if (fifo_rx_rd_en) rd_cnt++;
    chk("cfg_legal", 64'({DATA_CONFIG_REG[AW-1:2] != '0, &DATA_CONFIG_REG[1:0]}), 64'(0));
    chk("strobe_excl", 64'(fifo_tx_wr_en & fifo_rx_rd_en), 64'(0));
    if (in_cmd) chk("ready_busy", 64'(req_ready), 64'(0));
  endtask

  task automatic wait_cfg(input logic [1:0] v);
    int n = 0;
    while (DATA_CONFIG_REG[1:0] != v && n < 50) begin
      tick();
      n++;
    end
    chk("cfg_mode", 64'(DATA_CONFIG_REG), 64'(v));
  endtask

  // Present a request and check the round-robin grant against the model
  task automatic issue(input logic [1:0] mask, input logic [1:0] rw, input logic [63:0] wd,
                       input bit hold, output bit g);
    req_valid = mask;
    req_rw    = rw;
    req_wdata = wd;
    #1;
    g = mask[ptr_m] ? ptr_m : ~ptr_m;
    chk("grant", 64'(req_ready), 64'(g ? 2'b10 : 2'b01));
    ptr_m  = ~g;
    in_cmd = 1'b1;
    tick();
    if (!hold) req_valid = 2'b00;
  endtask

  // mode: 0 normal, 1 timeout, 2 core error at d1, 3 error together with RX data
  task automatic do_cmd(input logic [1:0] mask, input logic [1:0] rw, input logic [63:0] wd,
                        input int mode, input int tmo, input int fc, input int d1, input int d2,
                        input logic [31:0] rxv, input int rdly, input bit hold);
    bit          g, r;
    logic [31:0] w, exp_rd;
    logic [1:0]  exp_err;
    int          w0, r0, t0, n, exp_wr;
    tmo_cycles = TW'(tmo);
    w0 = wr_cnt;
    r0 = rd_cnt;
    issue(mask, rw, wd, hold, g);
    t0 = cyc;
    r  = rw[g];
    w  = g ? wd[63:32] : wd[31:0];
    exp_rd  = '0;
    exp_err = (mode == 1) ? 2'b01 : ((mode >= 2) ? 2'b10 : 2'b00);
    fifo_tx_f_full = !r && (mode == 1 || (mode == 0 && fc > 0));
    if (mode == 0 && !r) begin
      repeat (fc) tick();
      fifo_tx_f_full = 1'b0;
      wait_cfg(2'b01);
      repeat (d1) tick();
      i2c_idle = 1'b0;
      repeat (d2) tick();
      i2c_idle = 1'b1;
    end else if (mode == 0) begin
      wait_cfg(2'b10);
      repeat (d1) tick();
      RX_EMPTY = 1'b0;
      fifo_rx_data_out = rxv;
      n = 0;
      while (rd_cnt == r0 && n < 50) begin
        tick();
        n++;
      end
      RX_EMPTY = 1'b1;
      exp_rd = rxv;
    end else if (mode == 2) begin
      repeat (d1) tick();
      ERROR = 1'b1;
      tick();
      ERROR = 1'b0;
    end else if (mode == 3) begin
      wait_cfg(2'b10);
      ERROR = 1'b1;
      RX_EMPTY = 1'b0;
      tick();
      ERROR = 1'b0;
      RX_EMPTY = 1'b1;
    end
    n = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
    end
    chk("rsp_seen", 64'(rsp_valid), 64'(1));
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("cfg_cleared", 64'(DATA_CONFIG_REG), 64'(0));
    // Timeout counts only cycles spent waiting; the RX path passes GO_RX first
    if (mode == 1) chk("tmo_latency", 64'(cyc - t0), 64'(tmo + (r ? 1 : 0)));
    exp_wr = (mode == 0 && !r) ? 1 : 0;
    if (!(mode == 2 && !r)) chk("wr_pulses", 64'(wr_cnt - w0), 64'(exp_wr));
    if (mode == 0 && !r) chk("wr_data", 64'(last_wr), 64'(w));
    chk("rd_pulses", 64'(rd_cnt - r0), 64'((mode == 0 && r) ? 1 : 0));
    repeat (rdly) begin
      tick();
      chk("rsp_hold", 64'({rsp_valid, rsp_id, rsp_err, rsp_rdata}), 64'({1'b1, g, exp_err, exp_rd}));
    end
    in_cmd = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'(0));
    chk("idle_after", 64'(busy), 64'(0));
    fifo_tx_f_full = 1'b0;
  endtask

  initial begin
    bit g;
    rst = 1'b1; req_valid = '0; req_rw = '0; req_wdata = '0; rsp_ready = 1'b0;
    tmo_cycles = '0; fifo_tx_f_full = 1'b0; fifo_rx_data_out = '0; RX_EMPTY = 1'b1;
    i2c_idle = 1'b1; ERROR = 1'b0;
    total = 0; passed = 0; failed = 0; cyc = 0; wr_cnt = 0; rd_cnt = 0; last_wr = '0;
    in_cmd = 1'b0; ptr_m = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_outputs", 64'({rsp_valid, rsp_id, rsp_err, fifo_tx_wr_en, fifo_rx_rd_en, busy, req_ready}), 64'(0));
    chk("rst_data", 64'({rsp_rdata, fifo_tx_data_in}), 64'(0));
    chk("rst_regs", 64'({DATA_CONFIG_REG, TIMEOUT_TX}), 64'(0));
    rst = 1'b0;
    tick();

    // Requester 0 TX with core activity 3 cycles after enable, busy for 20
    do_cmd(2'b01, 2'b00, {32'h0, 32'hA5A5_0001}, 0, 0, 0, 3, 20, 32'h0, 1, 1'b0);
    // Requester 1 RX, data after 10 cycles
    do_cmd(2'b10, 2'b10, 64'h0, 0, 0, 0, 10, 1, 32'h0000_00C3, 0, 1'b0);
    // TX stuck on full FIFO, 8-cycle timeout
    do_cmd(2'b01, 2'b00, {32'h0, 32'h0000_1234}, 1, 8, 0, 0, 0, 32'h0, 0, 1'b0);
    chk("timeout_reg", 64'(TIMEOUT_TX), 64'(8));

    // Reset in the middle of a TX wait drops the command
    tmo_cycles = '0;
    issue(2'b01, 2'b00, {32'h0, 32'hDEAD_0001}, 1'b0, g);
    wait_cfg(2'b01);
    i2c_idle = 1'b0;
    tick();
    in_cmd = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_outputs", 64'({rsp_valid, rsp_id, rsp_err, fifo_tx_wr_en, fifo_rx_rd_en, busy, req_ready}), 64'(0));
    chk("midrst_regs", 64'({DATA_CONFIG_REG, TIMEOUT_TX}), 64'(0));
    chk("midrst_data", 64'({rsp_rdata, fifo_tx_data_in}), 64'(0));
    rst = 1'b0;
    i2c_idle = 1'b1;
    ptr_m = 1'b0;
    repeat (5) begin
      tick();
      chk("no_rsp_after_rst", 64'({rsp_valid, busy}), 64'(0));
    end

    // Both requesters always valid: grants alternate starting at 0
    for (int i = 0; i < 4; i++)
      do_cmd(2'b11, 2'b00, {$urandom, $urandom}, 0, 0, 0, 1, 2, 32'h0, 0, 1'b1);

    // Error coincides with RX data; response held back for 5 cycles with both valid
    do_cmd(2'b11, 2'b11, 64'h0, 3, 0, 0, 0, 0, 32'h0000_0055, 5, 1'b1);
    req_valid = 2'b00;
    tick();

    for (int i = 0; i < 30; i++) begin
      int mode, tmo;
      mode = int'($urandom_range(0, 2));
      tmo  = (mode == 1) ? int'($urandom_range(2, 20)) : (($urandom_range(0, 1) == 1) ? 0 : 500);
      do_cmd(2'($urandom_range(1, 3)), 2'($urandom), {$urandom, $urandom}, mode, tmo,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(1, 12)),
             $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end
    req_valid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
